hazard_controller: RTL and testbench

Pipeline sequencing controller for the execute stage of the RISC-V core. It detects load-use hazards between the instruction in ID and the load in EX, and inserts a bubble for them. It sequences multi-cycle multiply/divide operations through an external MDU using a start/done handshake, freezing the front of the pipeline while the operation runs. It also flushes the front of the pipeline after a taken branch. It sits beside the ID/EX and EX/MEM pipeline registers and drives their stall, bubble and flush controls; operand forwarding is handled elsewhere and is not affected.

---
 rtl/hazard_controller.sv | 104 ++++++++++
 tb/tb_hazard_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: execute-stage sequencing for load-use bubbles, MDU start/done stalls
// and taken-branch flushes.
module hazard_controller #(
    parameter int MDU_TIMEOUT  = 64,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memRead,
    input  logic        ex_isMulti,
    input  logic        branch_taken,
    input  logic        mdu_done,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        hold_ex,
    output logic        mdu_start,
    output logic        mdu_error,
    output logic [31:0] stall_count
);
    typedef enum logic [1:0] {RUN, MULTI_WAIT, FLUSH} stateT;

    stateT       state, stateNext;
    logic [31:0] waitCnt, waitNext, flushCnt, flushNext, stallCount;
    logic        errReg, errNext;
    logic        branch, multi, loadUse, inRun, inWait, inFlush;

    assign branch  = branch_taken && ex_valid;
    assign multi   = ex_valid && ex_isMulti;
    assign loadUse = ex_valid && ex_memRead && ex_rd != 5'd0 && id_valid
                     && (ex_rd == id_rs || ex_rd == id_rt);
    assign inRun   = state == RUN;
    assign inWait  = state == MULTI_WAIT;
    assign inFlush = state == FLUSH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            waitCnt    <= '0;
            flushCnt   <= '0;
            errReg     <= 1'b0;
            stallCount <= '0;
        end else begin
            state      <= stateNext;
            waitCnt    <= waitNext;
            flushCnt   <= flushNext;
            errReg     <= errNext;
            stallCount <= stallCount + {31'd0, stall_if};
        end
    end

    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        flushNext = flushCnt;
        errNext   = errReg;
        case (state)
            RUN: begin
                if (branch) begin
                    if (FLUSH_CYCLES > 1) begin
                        stateNext = FLUSH;
                        flushNext = 32'(FLUSH_CYCLES - 1);
                    end
                end else if (multi) begin
                    stateNext = MULTI_WAIT;
                    waitNext  = '0;
                end
            end
            MULTI_WAIT: begin
                if (mdu_done) begin
                    stateNext = RUN;
                end else if (waitCnt == 32'(MDU_TIMEOUT - 1)) begin
                    stateNext = RUN;
                    errNext   = 1'b1;
                end else begin
                    waitNext = waitCnt + 32'd1;
                end
            end
            FLUSH: begin
                flushNext = flushCnt - 32'd1;
                if (flushCnt == 32'd1) stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    // The timeout cycle still stalls; the abort takes effect from the following cycle.
    always_comb begin
        stall_if    = !rst && (inRun ? !branch && (multi || loadUse) : inWait && !mdu_done);
        stall_id    = stall_if;
        hold_ex     = !rst && (inRun ? !branch && multi : inWait && !mdu_done);
        bubble_ex   = !rst && (inRun ? branch || (!multi && loadUse) : inFlush);
        flush_id    = !rst && (inRun ? branch : inFlush);
        mdu_start   = !rst && inRun && !branch && multi;
        mdu_error   = !rst && errReg;
        stall_count = rst ? 32'd0 : stallCount;
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios plus randomized traffic against a cycle-level
// reference model of the sequencing rules.
module tb_hazard_controller;
    localparam int TO = 4;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst, id_valid, ex_valid, ex_memRead, ex_isMulti, branch_taken, mdu_done;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic stall_if, stall_id, bubble_ex, flush_id, hold_ex, mdu_start, mdu_error;
    logic [31:0] stall_count;

    int total = 0;
    int passed = 0;

    // Model: mode 0 = running, 1 = MDU busy (age = cycles since start), 2 = flushing.
    int mMode = 0, mAge = 0, mFlushLeft = 0;
    logic mErr = 1'b0;
    logic [31:0] mCount = '0;

    always #5 clk = ~clk;

    hazard_controller #(.MDU_TIMEOUT(TO), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_isMulti(ex_isMulti),
        .branch_taken(branch_taken), .mdu_done(mdu_done), .stall_if(stall_if),
        .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id), .hold_ex(hold_ex),
        .mdu_start(mdu_start), .mdu_error(mdu_error), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; ex_valid = 0; ex_rd = 0;
        ex_memRead = 0; ex_isMulti = 0; branch_taken = 0; mdu_done = 0;
    endtask

    // One clock: predict, check at the negedge, advance the model at the posedge.
    task automatic cycle(input string tag);
        logic br, mu, lu, eStall, eHold, eBub, eFlush, eStart;
        br = branch_taken && ex_valid;
        mu = ex_valid && ex_isMulti;
        lu = ex_valid && ex_memRead && ex_rd != 0 && id_valid && (ex_rd == id_rs || ex_rd == id_rt);
        eStall = 0; eHold = 0; eBub = 0; eFlush = 0; eStart = 0;
        if (!rst) begin
            if (mMode == 0) begin
                eFlush = br;
                eBub   = br || (!mu && lu);
                eStall = !br && (mu || lu);
                eHold  = !br && mu;
                eStart = !br && mu;
            end else if (mMode == 1) begin
                eStall = !mdu_done;
                eHold  = !mdu_done;
            end else begin
                eFlush = 1;
                eBub   = 1;
            end
        end
        @(negedge clk);
        chk({tag, ".stall_if"}, stall_if, eStall);
        chk({tag, ".stall_id"}, stall_id, eStall);
        chk({tag, ".hold_ex"}, hold_ex, eHold);
        chk({tag, ".bubble_ex"}, bubble_ex, eBub);
        chk({tag, ".flush_id"}, flush_id, eFlush);
        chk({tag, ".mdu_start"}, mdu_start, eStart);
        chk({tag, ".mdu_error"}, mdu_error, rst ? 1'b0 : mErr);
        chk({tag, ".stall_count"}, stall_count, rst ? 32'd0 : mCount);
        @(posedge clk);
        if (rst) begin
            mMode = 0; mAge = 0; mErr = 0; mCount = 0;
        end else begin
            if (eStall) mCount = mCount + 1;
            if (mMode == 0) begin
                if (br) begin
                    if (FC > 1) begin mMode = 2; mFlushLeft = FC - 1; end
                end else if (mu) begin
                    mMode = 1; mAge = 1;
                end
            end else if (mMode == 1) begin
                if (mdu_done) mMode = 0;
                else if (mAge == TO) begin mErr = 1; mMode = 0; end
                else mAge++;
            end else begin
                mFlushLeft--;
                if (mFlushLeft == 0) mMode = 0;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        cycle("reset");
        rst = 0;
        cycle("idle");

        ex_valid = 1; ex_memRead = 1; ex_rd = 5; id_valid = 1; id_rs = 5;
        cycle("loaduse");
        idle();
        cycle("loaduse_after");
        chk("loaduse_count", stall_count, 32'd1);
        ex_valid = 1; ex_memRead = 1; ex_rd = 0; id_valid = 1; id_rs = 0;
        cycle("loaduse_x0");
        idle();

        ex_valid = 1; ex_isMulti = 1;
        cycle("mul_start");
        idle();
        for (int i = 0; i < 3; i++) cycle("mul_wait");
        mdu_done = 1;
        cycle("mul_done");
        mdu_done = 0;
        cycle("mul_after");
        chk("mul_count", stall_count, 32'd5);
        chk("mul_noerr", mdu_error, 1'b0);

        ex_valid = 1; ex_isMulti = 1;
        cycle("to_start");
        idle();
        for (int i = 0; i < TO; i++) cycle("to_wait");
        chk("to_error", mdu_error, 1'b1);
        chk("to_count", stall_count, 32'd10);
        mdu_done = 1;
        cycle("to_late_done");
        idle();

        ex_valid = 1; branch_taken = 1; ex_isMulti = 1; ex_memRead = 1; ex_rd = 3; id_valid = 1; id_rt = 3;
        cycle("br_multi");
        idle();
        for (int i = 0; i < FC; i++) cycle("br_tail");

        ex_valid = 1; ex_isMulti = 1;
        cycle("rst_mul_start");
        idle();
        cycle("rst_wait1");
        cycle("rst_wait2");
        rst = 1;
        cycle("rst_mid");
        rst = 0; mdu_done = 1;
        cycle("rst_done_ignored");
        idle();
        chk("rst_count", stall_count, 32'd0);
        chk("rst_err", mdu_error, 1'b0);

        force dut.stallCount = 32'hFFFF_FFFF;
        #1 release dut.stallCount;
        mCount = 32'hFFFF_FFFF;
        ex_valid = 1; ex_memRead = 1; ex_rd = 7; id_valid = 1; id_rt = 7;
        cycle("wrap");
        idle();
        chk("wrap_count", stall_count, 32'd0);

        for (int i = 0; i < 500; i++) begin
            rst          = $urandom_range(0, 59) == 0;
            id_valid     = $urandom_range(0, 3) != 0;
            ex_valid     = $urandom_range(0, 3) != 0;
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_memRead   = $urandom_range(0, 1) == 1;
            ex_isMulti   = $urandom_range(0, 5) == 0;
            branch_taken = $urandom_range(0, 7) == 0;
            mdu_done     = $urandom_range(0, 4) == 0;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
